// File: rtl/mux_rr_reg.sv
// mux_rr_reg
//   N-input, W-bit registered multiplexer with valid/ready on every input and
//   on the output. In direct mode the channel comes from a saturating select.
//   In round-robin mode the grant rotates fairly among the valid inputs. The
//   output is a single registered pipeline stage.
//
// Handshake: a word moves across an interface on a rising clock edge where
//   valid and ready are both high. A producer may drop valid at any time.
//   in_ready is combinational and one-hot or zero. The output stage holds
//   out_data/out_chan/out_valid stable while out_valid && !out_ready.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   mode       0 = direct select, 1 = round-robin
//   select     channel select in direct mode; codes >= NUM_IN-1 pick NUM_IN-1
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, at most one bit high
//   out_data   registered output word
//   out_valid  registered output valid
//   out_chan   channel that supplied out_data
//   out_ready  downstream accept
//
// SEL_W must satisfy 2**SEL_W >= NUM_IN; NUM_IN is 2..16.
module mux_rr_reg #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] last_grant;
  logic             load_en;
  logic [SEL_W-1:0] sel_eff;
  logic             dir_valid;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             gnt_valid;
  logic             transfer;
  logic [WIDTH-1:0] grant_data;

  // The register can accept a new word when it is empty or being drained.
  assign load_en = !out_valid || out_ready;

  // Direct mode: saturate out-of-range select codes onto the last channel.
  assign sel_eff = (select >= LAST_CHAN) ? LAST_CHAN : select;

  always_comb begin
    dir_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_eff == SEL_W'(i)) dir_valid = in_valid[i];
    end
  end

  // Round-robin: the first valid channel strictly above last_grant wins;
  // if none, wrap and take the lowest valid channel (which may be
  // last_grant itself when it is the only requester).
  always_comb begin
    logic             found_hi;
    logic             found_lo;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found_hi && in_valid[i] && (SEL_W'(i) > last_grant)) begin
        found_hi = 1'b1;
        hi_idx   = SEL_W'(i);
      end
      if (!found_lo && in_valid[i]) begin
        found_lo = 1'b1;
        lo_idx   = SEL_W'(i);
      end
    end
    rr_grant = found_hi ? hi_idx : lo_idx;
    rr_valid = |in_valid;
  end

  assign grant     = mode ? rr_grant : sel_eff;
  assign gnt_valid = mode ? rr_valid : dir_valid;
  // gnt_valid already implies in_valid[grant], so this is the handshake.
  assign transfer  = load_en && gnt_valid;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = transfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      last_grant <= LAST_CHAN;
    end else if (transfer) begin
      out_data   <= grant_data;
      out_chan   <= grant;
      out_valid  <= 1'b1;
      last_grant <= grant;
    end else if (out_valid && out_ready) begin
      // Drained with nothing to refill: keep data/chan, drop valid.
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
module tb_mux_rr_reg;

  localparam int NUM_IN = 4;
  localparam int WIDTH  = 8;
  localparam int SEL_W  = 3;

  logic                    clock;
  logic                    reset;
  logic                    mode;
  logic [SEL_W-1:0]        select;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SEL_W+WIDTH-1:0] exp_q[$];
  logic                   hs;

  mux_rr_reg #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: change inputs just after a rising edge, return at the falling edge
  task automatic step(input logic m, input logic [SEL_W-1:0] s,
                      input logic [NUM_IN-1:0] v, input logic r);
    @(posedge clock);
    #1;
    mode      = m;
    select    = s;
    in_valid  = v;
    out_ready = r;
    @(negedge clock);
  endtask

  task automatic push(input int ch, input logic [WIDTH-1:0] d);
    exp_q.push_back({SEL_W'(ch), d});
  endtask

  // scoreboard: note a handshake at each edge, compare the word half a cycle later
  always @(posedge clock or posedge reset) begin
    if (reset) hs <= 1'b0;
    else       hs <= |(in_ready & in_valid);
  end

  always @(negedge clock) begin
    logic [SEL_W+WIDTH-1:0] e;
    if (hs) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_unexpected: observed chan %0d data %0h expected none", out_chan, out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_valid", 32'(out_valid), 32'd1);
        check("sb_chan",  32'(out_chan),  32'(e[SEL_W+WIDTH-1:WIDTH]));
        check("sb_data",  32'(out_data),  32'(e[WIDTH-1:0]));
      end
    end
  end

  initial begin
    int rr_seq[6];
    rr_seq = '{0, 1, 3, 0, 1, 3};

    reset     = 1'b1;
    mode      = 1'b0;
    select    = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};

    // reset then idle
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_chan",  32'(out_chan),  32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data",  32'(out_data),  32'd0);
    check("idle_chan",  32'(out_chan),  32'd0);
    check("idle_ready", 32'(in_ready),  32'd0);

    // direct select with clamp
    step(1'b0, 3'd1, 4'b1111, 1'b1);
    check("dir_ready_sel1", 32'(in_ready), 32'b0010);
    push(1, 8'h21);
    step(1'b0, 3'd6, 4'b1111, 1'b1);
    check("dir_ready_sel6", 32'(in_ready), 32'b1000);
    push(3, 8'h43);
    step(1'b0, 3'd5, 4'b0111, 1'b1);
    check("dir_clamp_invalid", 32'(in_ready), 32'b0000);

    // round-robin fairness: last served was ch3, so ch0 is next
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 3'd0, 4'b1011, 1'b1);
      check("rr_ready", 32'(in_ready), 32'(1) << rr_seq[k]);
      push(rr_seq[k], (rr_seq[k] == 0) ? 8'h10 : (rr_seq[k] == 1) ? 8'h21 : 8'h43);
    end
    step(1'b1, 3'd0, 4'b0000, 1'b1);
    check("rr_idle_ready", 32'(in_ready), 32'd0);
    step(1'b1, 3'd0, 4'b0000, 1'b1);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data",  32'(out_data),  32'h43);
    check("drain_chan",  32'(out_chan),  32'd3);

    // backpressure
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    step(1'b0, 3'd2, 4'b0100, 1'b1);
    check("bp_load_ready", 32'(in_ready), 32'b0100);
    push(2, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 3'd0, 4'b0011, 1'b0);
      check("bp_data",  32'(out_data),  32'hA5);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_chan",  32'(out_chan),  32'd2);
      check("bp_ready", 32'(in_ready),  32'd0);
    end
    step(1'b1, 3'd0, 4'b0011, 1'b1);
    check("bp_release_ready", 32'(in_ready), 32'b0001);
    push(0, 8'h10);

    // consume without refill, then single refill
    step(1'b1, 3'd0, 4'b0000, 1'b1);
    check("cons_ready", 32'(in_ready), 32'd0);
    step(1'b1, 3'd0, 4'b0000, 1'b1);
    check("cons_valid", 32'(out_valid), 32'd0);
    check("cons_hold",  32'(out_data),  32'h10);
    step(1'b1, 3'd0, 4'b0010, 1'b1);
    check("refill_ready", 32'(in_ready), 32'b0010);
    push(1, 8'h21);

    // async reset in the middle of a stall
    step(1'b1, 3'd0, 4'b0000, 1'b0);
    check("stall_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_data",  32'(out_data),  32'd0);
    check("async_chan",  32'(out_chan),  32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    step(1'b1, 3'd0, 4'b1111, 1'b1);
    check("post_rst_ready", 32'(in_ready), 32'b0001);
    push(0, 8'h10);
    repeat (3) step(1'b1, 3'd0, 4'b0000, 1'b1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. It has two modes. Direct mode takes a select input, clamped so that any select at or above the last channel picks the last channel. Round-robin mode grants fairly among the valid inputs. It sits between multiple producer channels and a single downstream consumer, and provides one registered output stage.

Parameters:
NUM_IN, 4, number of input channels (2..16)
WIDTH, 8, data width per channel
SEL_W, 2, width of select/out_chan; must satisfy 2**SEL_W >= NUM_IN

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mode  input  1  0 = direct select, 1 = round-robin
select  input  SEL_W  channel select in direct mode; ignored in round-robin mode
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-channel data valid
in_ready  output  NUM_IN  per-channel accept, combinational; at most one bit high
out_data  output  WIDTH  registered output data
out_valid  output  1  registered output valid
out_chan  output  SEL_W  index of the channel that supplied out_data
out_ready  input  1  downstream accept

Behaviour:
- Clock and reset: single clock domain, clock; reset asynchronous, active-high.
- Reset values:
  - out_data = 0, out_valid = 0, out_chan = 0.
  - Round-robin pointer last_grant = NUM_IN-1, so channel 0 has first priority after reset.
  - Reset asserted mid-transfer discards the held word immediately; no input transfer is counted.
- Load enable: load_en = !out_valid || out_ready. The output register is a one-deep pipeline stage and sustains full throughput when out_ready is held high.
- Direct mode (mode=0):
  - sel_eff = (select >= NUM_IN-1) ? NUM_IN-1 : select.
  - grant = sel_eff; gnt_valid = in_valid[sel_eff].
- Round-robin mode (mode=1):
  - grant is the first i with in_valid[i]=1, searching last_grant+1, last_grant+2, … modulo NUM_IN.
  - gnt_valid = |in_valid.
- in_ready[i] = load_en && gnt_valid && (grant == i). All in_ready bits are 0 while the output is stalled (out_valid && !out_ready).
- Transfer (in_ready[grant] && in_valid[grant]), on the next rising edge:
  - out_data <= in_data[grant]; out_chan <= grant; out_valid <= 1.
  - last_grant <= grant. last_grant updates in both modes, so switching to round-robin continues from the last served channel.
- Output consumed with no new transfer (out_valid && out_ready && !gnt_valid): out_valid <= 0; out_data and out_chan hold their last values.
- Stall: while out_valid && !out_ready, out_data, out_chan and out_valid are held stable; last_grant does not change.
- Simultaneous consume and load in the same cycle: the new word replaces the old one and out_valid stays 1, giving zero bubble.
- Latency: one cycle from input handshake to out_valid.
- Mode or select changes: take effect in the same cycle's combinational grant. A word already held in the register is unaffected.
- Inputs are not required to hold in_valid after it is asserted. A deasserted valid simply loses arbitration.
- Pointer wrap: after a grant of NUM_IN-1, the search starts at channel 0.
- Unused select codes (NUM_IN..2**SEL_W-1): clamp to NUM_IN-1, matching the saturating priority of the earlier 3-input mux.

Test Plan:
- Reset then idle: assert reset for 3 cycles with all in_valid=0 -> out_valid=0, out_data=0, out_chan=0, in_ready=0000. Release reset and wait 5 cycles -> outputs unchanged.
- Direct select with clamp (NUM_IN=4, SEL_W=3, out_ready=1, in_data ch0..3 = 8'h10/8'h21/8'h32/8'h43, all valid):
  - select=1 -> next cycle out_data=8'h21, out_chan=1.
  - select=6 -> out_data=8'h43, out_chan=3.
  - in_ready is one-hot on the clamped channel.
- Round-robin fairness (mode=1, in_valid=1011 held, out_ready=1) -> out_chan sequence 0,1,3,0,1,3, one word per cycle with no bubbles.
- Backpressure: load 8'hA5 from ch2, then hold out_ready=0 for 4 cycles while ch0 and ch1 are valid -> out_data=8'hA5, out_valid=1, in_ready=0000 throughout. When out_ready rises, the next word comes from ch0 the following cycle (pointer was at 2, so wrap to 3 is invalid, then 0).
- Consume without refill: out_valid=1 and out_ready=1 with in_valid=0000 -> out_valid=0 the next cycle while out_data holds its value. Then assert in_valid[1] -> out_valid=1 after one cycle with out_chan=1.
- Async reset mid-stall: assert reset between clock edges while out_valid=1 -> out_valid drops to 0 immediately without waiting for a clock edge. After release, round-robin with all channels valid grants ch0 first.
